// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - three-digit seven-segment scan driver with frame-synchronous result update
// Outputs are registered from next-state values, so each cycle's seg/an match that cycle's slot position.
module display_scan_controller #(
  parameter int N            = 5,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] num,
  input  logic         negative,
  input  logic         overflow,
  output logic [6:0]   seg,
  output logic [2:0]   an,
  output logic         pending,
  output logic         frame_tick
);

  localparam int PW = $clog2(DIV);
  localparam int BW = $clog2(BLINK_FRAMES);

  localparam logic [1:0] SLOT_UNITS = 2'd0;
  localparam logic [1:0] SLOT_TENS  = 2'd1;
  localparam logic [1:0] SLOT_SIGN  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 7'b1000000;
      4'd1:    digit_code = 7'b1111001;
      4'd2:    digit_code = 7'b0100100;
      4'd3:    digit_code = 7'b0110000;
      4'd4:    digit_code = 7'b0011001;
      4'd5:    digit_code = 7'b0010010;
      4'd6:    digit_code = 7'b0000010;
      4'd7:    digit_code = 7'b1111000;
      4'd8:    digit_code = 7'b0000000;
      4'd9:    digit_code = 7'b0010000;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

  logic [PW-1:0] presc, presc_next;
  logic [1:0]    slot, slot_next;
  logic          tc, boundary;

  logic [N-1:0]  shd_mag, act_mag, load_mag;
  logic          shd_neg, shd_ovf, act_neg, act_ovf;
  logic [BW-1:0] blink_cnt;

  logic [7:0]    mag_ext;
  logic [3:0]    tens_d, units_d;
  logic          too_big, blink_off, tick_d;
  logic [6:0]    seg_d;
  logic [2:0]    an_d;

  // Shadow stores the magnitude directly; the sign flag is kept separately for the sign digit.
  assign load_mag = negative ? (~num + 1'b1) : num;

  always_comb begin
    tc         = (presc == PW'(DIV - 1));
    boundary   = tc && (slot == SLOT_SIGN);
    presc_next = tc ? '0 : presc + 1'b1;
    slot_next  = slot;
    if (tc) begin
      case (slot)
        SLOT_UNITS: slot_next = SLOT_TENS;
        SLOT_TENS:  slot_next = SLOT_SIGN;
        default:    slot_next = SLOT_UNITS;
      endcase
    end
  end

  // Active registers and blink counter only change on edges that enter a blank gap cycle,
  // so using their current values for the next cycle's outputs is safe.
  always_comb begin
    mag_ext   = 8'(act_mag);
    tens_d    = 4'(mag_ext / 8'd10);
    units_d   = 4'(mag_ext % 8'd10);
    too_big   = (mag_ext > 8'd99);
    blink_off = act_ovf && (blink_cnt >= BW'(BLINK_FRAMES / 2));
    tick_d    = (presc_next == PW'(DIV - 1)) && (slot_next == SLOT_SIGN);
    seg_d     = SEG_BLANK;
    an_d      = 3'b111;
    if ((presc_next != '0) && !blink_off) begin
      case (slot_next)
        SLOT_UNITS: begin
          an_d  = 3'b110;
          seg_d = too_big ? SEG_DASH : digit_code(units_d);
        end
        SLOT_TENS: begin
          if (too_big) begin
            an_d  = 3'b101;
            seg_d = SEG_DASH;
          end else if (tens_d != 4'd0) begin
            an_d  = 3'b101;
            seg_d = digit_code(tens_d);
          end
        end
        SLOT_SIGN: begin
          if (act_neg && (act_mag != '0)) begin
            an_d  = 3'b011;
            seg_d = SEG_DASH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      slot       <= SLOT_UNITS;
      seg        <= SEG_BLANK;
      an         <= 3'b111;
      frame_tick <= 1'b0;
      pending    <= 1'b0;
      blink_cnt  <= '0;
      shd_mag    <= '0;
      shd_neg    <= 1'b0;
      shd_ovf    <= 1'b0;
      act_mag    <= '0;
      act_neg    <= 1'b0;
      act_ovf    <= 1'b0;
    end else begin
      presc      <= presc_next;
      slot       <= slot_next;
      seg        <= seg_d;
      an         <= an_d;
      frame_tick <= tick_d;
      if (load) begin
        shd_mag <= load_mag;
        shd_neg <= negative;
        shd_ovf <= overflow;
      end
      if (boundary) begin
        if (pending) begin
          act_mag   <= shd_mag;
          act_neg   <= shd_neg;
          act_ovf   <= shd_ovf;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
        end
      end
      if (load) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed scoreboard bench for display_scan_controller (N=5, DIV=4, BLINK_FRAMES=4)
module tb_display_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [4:0] num;
  logic       negative;
  logic       overflow;
  logic [6:0] seg;
  logic [2:0] an;
  logic       pending;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Per-slot expectation {an, seg}; index 0 = units, 1 = tens, 2 = sign.
  typedef logic [2:0][9:0] frame_t;
  frame_t sb[$];

  localparam logic [9:0] OFF = {3'b111, 7'b1111111};

  display_scan_controller #(.N(5), .DIV(4), .BLINK_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .load(load), .num(num), .negative(negative), .overflow(overflow),
    .seg(seg), .an(an), .pending(pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic frame_t expect_frame(input int value, input bit neg, input bit blanked);
    frame_t f;
    int mag;
    mag = neg ? ((32 - value) % 32) : value;
    f = {OFF, OFF, OFF};
    if (!blanked) begin
      f[0] = {3'b110, seg_of(mag % 10)};
      if (mag / 10 != 0) f[1] = {3'b101, seg_of(mag / 10)};
      if (neg && mag != 0) f[2] = {3'b011, 7'b0111111};
    end
    return f;
  endfunction

  task automatic do_load(input logic [4:0] v, input logic neg, input logic ovf);
    num = v;
    negative = neg;
    overflow = ovf;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pending_after_load", pending, 1);
  endtask

  task automatic wait_frame_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    check("frame_tick_timeout", frame_tick, 1);
  endtask

  // Starts at the negedge of a frame_tick cycle and samples all 12 cycles of the next frame.
  task automatic scan_frame(input string tag);
    frame_t e;
    logic [9:0] exp;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        load = 1'b0;
        exp = (c == 0) ? OFF : e[s];
        check($sformatf("%s_slot%0d_c%0d", tag, s, c), {an, seg}, exp);
        check($sformatf("%s_tick%0d_c%0d", tag, s, c), frame_tick, (s == 2 && c == 3));
      end
    end
  endtask

  initial begin
    int n;
    frame_t v3, b3;
    rst = 1'b1;
    load = 1'b0;
    num = '0;
    negative = 1'b0;
    overflow = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_an_seg", {an, seg}, OFF);
    check("reset_pending", pending, 0);
    check("reset_frame_tick", frame_tick, 0);
    rst = 1'b0;
    wait_frame_tick(n);
    check("reset_frame_len", n, 11);
    sb.push_back(expect_frame(0, 0, 0));
    scan_frame("zero");

    @(negedge clk);
    do_load(5'b11001, 1'b1, 1'b0);
    sb.push_back(expect_frame(25, 1, 0));
    wait_frame_tick(n);
    check("neg7_pending_at_tick", pending, 1);
    scan_frame("neg7");
    check("neg7_pending_cleared", pending, 0);

    @(negedge clk);
    do_load(5'd13, 1'b0, 1'b0);
    sb.push_back(expect_frame(13, 0, 0));
    do_load(5'd4, 1'b0, 1'b0);
    void'(sb.pop_back());
    sb.push_back(expect_frame(4, 0, 0));
    wait_frame_tick(n);
    check("last_wins_pending_at_tick", pending, 1);
    scan_frame("last_wins");
    check("last_wins_pending_cleared", pending, 0);

    @(negedge clk);
    do_load(5'b10000, 1'b1, 1'b0);
    sb.push_back(expect_frame(16, 1, 0));
    wait_frame_tick(n);
    scan_frame("neg16");

    v3 = expect_frame(3, 0, 0);
    b3 = expect_frame(3, 0, 1);
    @(negedge clk);
    do_load(5'd3, 1'b0, 1'b1);
    sb.push_back(v3); sb.push_back(v3); sb.push_back(b3);
    sb.push_back(b3); sb.push_back(v3); sb.push_back(v3);
    wait_frame_tick(n);
    for (int i = 0; i < 6; i++) scan_frame($sformatf("blink%0d", i));

    @(negedge clk);
    do_load(5'd3, 1'b0, 1'b1);
    sb.push_back(v3); sb.push_back(v3); sb.push_back(b3);
    wait_frame_tick(n);
    for (int i = 0; i < 3; i++) scan_frame($sformatf("blink_restart%0d", i));

    @(negedge clk);
    do_load(5'd8, 1'b0, 1'b0);
    sb.push_back(expect_frame(8, 0, 0));
    wait_frame_tick(n);
    num = 5'd21;
    negative = 1'b0;
    overflow = 1'b0;
    load = 1'b1;
    sb.push_back(expect_frame(21, 0, 0));
    scan_frame("coincide_old");
    check("coincide_pending_kept", pending, 1);
    scan_frame("coincide_new");
    check("coincide_pending_cleared", pending, 0);

    repeat (4) @(negedge clk);
    do_load(5'd9, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_reset_tens_shown", {an, seg}, {3'b101, 7'b0100100});
    rst = 1'b1;
    @(negedge clk);
    check("midslot_reset_an_seg", {an, seg}, OFF);
    check("midslot_reset_pending", pending, 0);
    check("midslot_reset_frame_tick", frame_tick, 0);
    rst = 1'b0;
    wait_frame_tick(n);
    check("midslot_reset_frame_len", n, 11);
    sb.push_back(expect_frame(0, 0, 0));
    scan_frame("post_reset");
    check("post_reset_pending", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexed driver for the three-digit seven-segment result display: sign, tens and units share one segment bus.
- Latches ALU results into a shadow register and applies them only at frame boundaries, so a frame never shows half-old, half-new digits.
- Scans the digits with a refresh prescaler, blanks a leading-zero tens digit, and blinks the whole display while the ALU overflow flag is set.
- Sits between the ALU result/flags and the board's segment and anode pins.

Parameters:
- N, 5: width of num. Legal range 2..7.
- DIV, 50000: clock cycles per digit slot. Must be ≥2.
- BLINK_FRAMES, 64: overflow blink period in frames. Must be even and ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  capture num/negative/overflow this cycle
- num  in  N  ALU result; two's complement when negative=1
- negative  in  1  result is negative
- overflow  in  1  ALU overflow flag
- seg  out  7  active-low segments {g,f,e,d,c,b,a}; seg[6]=g
- an  out  3  active-low digit enables: an[0]=units, an[1]=tens, an[2]=sign
- pending  out  1  shadow holds a value not yet displayed
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values, applied on the first edge with rst=1, including mid-frame:
  - seg=7'b1111111, an=3'b111, pending=0, frame_tick=0.
  - Prescaler=0, slot=UNITS, blink counter=0.
  - Shadow and active registers cleared (mag 0, positive, no overflow).
- Magnitude: mag = negative ? (~num+1) truncated to N bits : num. Example: num=5'b10000 with negative=1 gives mag=16.
- Prescaler counts 0..DIV-1. At terminal count (TC) the slot advances UNITS→TENS→SIGN→UNITS.
- Frame boundary = TC while slot=SIGN. frame_tick is 1 in that cycle.
- Outputs are registered.
  - In the first cycle of every slot (prescaler=0): an=111 and seg=1111111 (anti-ghost gap).
  - In the rest of the slot: the slot's an bit is low and seg carries that digit's code.
- Digit codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank=1111111, dash=0111111.
- Digit contents from the active registers:
  - Units = code(mag%10).
  - Tens = code(mag/10); blank (an stays high for the slot) if mag/10==0.
  - Sign = dash if negative and mag≠0, else blank with an high. Negative zero shows no sign.
  - If mag>99, units and tens both show dash.
- Load handling:
  - load=1 copies num/negative/overflow into the shadow and sets pending=1 on the next edge.
  - Several loads before a boundary: the last one wins.
- At a frame boundary with pending=1: shadow→active, pending→0, blink counter→0. New digits appear from the next UNITS slot.
- load coincident with a boundary: the previous shadow is applied; the new value overwrites the shadow; pending stays 1 and the value is applied at the next boundary.
- Blink:
  - The blink counter increments at each boundary (modulo BLINK_FRAMES) when no transfer occurs.
  - If active overflow=1 and counter ≥ BLINK_FRAMES/2, all slots are blanked: an=111, seg=1111111.
  - With overflow=0, the display never blanks.
- Display content changes only at frame boundaries or on reset.

Test Plan:
(bench uses DIV=4, BLINK_FRAMES=4)
- Reset → an=111, seg=1111111. Then in the units slot, cycles 1..3: an=110, seg=1000000. Tens and sign slots: an=111.
- Load num=5'b11001, negative=1 → pending=1 until the boundary. Next frame: units 1111000 (7), tens an=111, sign an=011 with seg=0111111.
- Load num=13, then num=4 (positive) before the boundary → only "4" is displayed (0011001); pending goes 0 at frame_tick.
- Load num=5'b10000, negative=1 → units 0000010 (6), tens 1111001 (1), sign dash.
- Load num=3, overflow=1 → "3" visible for 2 frames, then an=111 for the whole of 2 frames; the pattern repeats. A fresh load restarts the blink at the visible phase.
- Load asserted exactly in the frame_tick cycle → the old shadow is applied and pending stays 1; the new value appears one frame later. Assert rst mid-slot → all reset values on the next edge.
